// File: rtl/fsm_cmd_pkg.sv
// Shared types and constants for the command driver that feeds the downstream control FSM.
package fsm_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_RETRY = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [2:0] DEF_SAFE_CODE = 3'b000;

  function automatic logic code_is_legal(input logic [31:0] code, input int unsigned num_legal);
    return code < num_legal;
  endfunction

endpackage

// File: rtl/fsm_cmd_timer.sv
// Saturating up-counter used to time out the echo wait; expired holds once LIMIT is reached.
module fsm_cmd_timer #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = 8'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  // Counting stops at LIMIT (or above it after a large load), so the value never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg < LIMIT)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign expired = (count_reg >= LIMIT);

endmodule

// File: rtl/fsm_cmd_driver.sv
// Initiator for the user-input command bus: drives a code, waits for the FSM echo,
// retries on timeout and reports done or a classified error.
module fsm_cmd_driver
  import fsm_cmd_pkg::*;
#(
  parameter int unsigned       CODE_W      = 3,
  parameter int unsigned       NUM_LEGAL   = 4,
  parameter int unsigned       TIMEOUT_CYC = 8,
  parameter int unsigned       MAX_RETRY   = 2,
  parameter logic [CODE_W-1:0] SAFE_CODE   = CODE_W'(DEF_SAFE_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CODE_W-1:0] cmd_code,
  output logic              cmd_ready,
  output logic [CODE_W-1:0] user_input,
  input  logic [CODE_W-1:0] fsm_out,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            state_reg, state_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [CODE_W-1:0] user_input_reg, user_input_next;
  logic [2:0]        retry_reg, retry_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              timer_clear, timer_en, timer_expired;

  fsm_cmd_timer #(
    .WIDTH (8),
    .LIMIT (8'(TIMEOUT_CYC - 1))
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .load       (1'b0),
    .load_value (8'd0),
    .en         (timer_en),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      code_reg       <= SAFE_CODE;
      user_input_reg <= SAFE_CODE;
      retry_reg      <= '0;
      cmd_ready_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      code_reg       <= code_next;
      user_input_reg <= user_input_next;
      retry_reg      <= retry_next;
      cmd_ready_reg  <= cmd_ready_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    code_next       = code_reg;
    user_input_next = user_input_reg;
    retry_next      = retry_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;
    err_code_next   = err_code_reg;
    timer_clear     = 1'b0;
    timer_en        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        user_input_next = SAFE_CODE;
        if (cmd_valid && cmd_ready_reg) begin
          if (code_is_legal(32'(cmd_code), NUM_LEGAL)) begin
            code_next  = cmd_code;
            retry_next = '0;
            state_next = S_DRIVE;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_ILLEGAL;
            state_next    = S_ERR;
          end
        end
      end
      S_DRIVE: begin
        user_input_next = code_reg;
        timer_clear     = 1'b1;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        timer_en = 1'b1;
        // An echo seen on the timeout cycle still counts as success.
        if (fsm_out == code_reg) begin
          done_next       = 1'b1;
          user_input_next = SAFE_CODE;
          state_next      = S_IDLE;
        end else if (timer_expired) begin
          if (retry_reg < 3'(MAX_RETRY)) begin
            retry_next = retry_reg + 3'd1;
            state_next = S_RETRY;
          end else begin
            err_next        = 1'b1;
            err_code_next   = ERR_TIMEOUT;
            user_input_next = SAFE_CODE;
            state_next      = S_ERR;
          end
        end
      end
      S_RETRY: begin
        // One safe-code cycle so the FSM sees a fresh transition on re-drive.
        user_input_next = SAFE_CODE;
        state_next      = S_DRIVE;
      end
      S_ERR: begin
        user_input_next = SAFE_CODE;
        state_next      = S_IDLE;
      end
      default: begin
        user_input_next = SAFE_CODE;
        state_next      = S_IDLE;
      end
    endcase

    cmd_ready_next = (state_next == S_IDLE);
  end

  assign cmd_ready  = cmd_ready_reg;
  assign user_input = user_input_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_fsm_cmd_driver.sv
// Directed bench for fsm_cmd_driver: handshake, illegal code, timeout/retry, echo-on-timeout,
// asynchronous abort and back-to-back commands, checked against hand-computed values.
module tb_fsm_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [2:0] user_input;
  logic [2:0] fsm_out;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  logic       echo_mode;
  logic [2:0] stuck;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Echo model: either an immediate combinational echo or a value held by the bench.
  assign fsm_out = echo_mode ? user_input : stuck;

  fsm_cmd_driver dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .user_input (user_input),
    .fsm_out    (fsm_out),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int drives;
    int ones;
    int err_cnt;
    int done_cnt;
    int err_edge;
    logic [1:0] ec_at_err;
    logic [2:0] prev;
    logic [2:0] ui_hist [0:40];

    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 3'd0; echo_mode = 1'b0; stuck = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_ui", user_input, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    // Legal code 2 with immediate echo
    echo_mode = 1'b1; cmd_code = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t1_ready_busy", cmd_ready, 0);
    check("t1_ui_e0", user_input, 0);
    tick();
    check("t1_ui_drive", user_input, 2);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_ui_safe", user_input, 0);
    check("t1_ready_back", cmd_ready, 1);
    tick();
    check("t1_done_pulse", done, 0);

    // Illegal code 5
    echo_mode = 1'b0; stuck = 3'd0; cmd_code = 3'd5; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t2_err", err, 1);
    check("t2_err_code", err_code, 1);
    check("t2_ui", user_input, 0);
    check("t2_done", done, 0);
    check("t2_ready", cmd_ready, 0);
    tick();
    check("t2_err_pulse", err, 0);
    check("t2_err_code_hold", err_code, 1);
    check("t2_ready_back", cmd_ready, 1);

    // Code 1 with fsm_out stuck at 0: three drives then timeout error
    cmd_code = 3'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    drives = 0; ones = 0; err_cnt = 0; done_cnt = 0; err_edge = -1; ec_at_err = 2'b00;
    prev = user_input;
    for (int k = 1; k <= 34; k++) begin
      tick();
      ui_hist[k] = user_input;
      if (user_input == 3'd1) begin
        ones++;
        if (prev != 3'd1) drives++;
      end
      if (err) begin
        err_cnt++;
        err_edge = k;
        ec_at_err = err_code;
      end
      if (done) done_cnt++;
      prev = user_input;
    end
    check("t3_drives", drives, 3);
    check("t3_drive_cycles", ones, 26);
    check("t3_gap1", ui_hist[10], 0);
    check("t3_gap2", ui_hist[20], 0);
    check("t3_ui_at_err", ui_hist[29], 0);
    check("t3_err_count", err_cnt, 1);
    check("t3_err_edge", err_edge, 29);
    check("t3_err_code", ec_at_err, 2);
    check("t3_no_done", done_cnt, 0);
    check("t3_ready_back", cmd_ready, 1);

    // Echo arrives exactly on the timeout cycle of the first attempt
    stuck = 3'd0; cmd_code = 3'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    check("t4_done_early", done, 0);
    check("t4_ui_held", user_input, 2);
    stuck = 3'd2;
    tick();
    check("t4_done", done, 1);
    check("t4_err", err, 0);
    check("t4_ui_safe", user_input, 0);
    stuck = 3'd0;
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_no_retry_a", user_input, 0);
    tick();
    check("t4_no_retry_b", user_input, 0);
    check("t4_no_err", err, 0);

    // Asynchronous reset while waiting with user_input=3
    cmd_code = 3'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("t5_ui_wait", user_input, 3);
    #2 rst = 1'b1;
    #1;
    check("t5_ui_async", user_input, 0);
    check("t5_ready_rst", cmd_ready, 0);
    #3 rst = 1'b0;
    tick();
    check("t5_ready_back", cmd_ready, 1);
    check("t5_ui_idle", user_input, 0);
    check("t5_err_code", err_code, 0);
    for (int k = 0; k < 3; k++) begin
      check("t5_no_done", done, 0);
      check("t5_no_err", err, 0);
      tick();
    end

    // Back-to-back 0, 3, 6 with cmd_valid held high
    echo_mode = 1'b1; cmd_code = 3'd0; cmd_valid = 1'b1;
    tick();
    check("t6_ready_e0", cmd_ready, 0);
    check("t6_done_e0", done, 0);
    cmd_code = 3'd3;
    tick();
    check("t6_ui_e1", user_input, 0);
    check("t6_ready_e1", cmd_ready, 0);
    tick();
    check("t6_done_0", done, 1);
    check("t6_ready_e2", cmd_ready, 1);
    tick();
    check("t6_done_e3", done, 0);
    check("t6_ready_e3", cmd_ready, 0);
    cmd_code = 3'd6;
    tick();
    check("t6_ui_3", user_input, 3);
    tick();
    check("t6_done_3", done, 1);
    check("t6_ready_e5", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t6_err_6", err, 1);
    check("t6_err_code_6", err_code, 1);
    check("t6_done_e6", done, 0);
    check("t6_ready_e6", cmd_ready, 0);
    tick();
    check("t6_err_pulse", err, 0);
    check("t6_ready_end", cmd_ready, 1);
    check("t6_done_end", done, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
